// File: rtl/box_sprite_gen.sv
// Draws NUM_BOXES solid square sprites that bounce inside the active video area.
// Positions step once per frame on the vSync falling edge; colour out has 2-clk latency.
module box_sprite_gen #(
    parameter int NUM_BOXES = 4,
    parameter int COORD_W   = 11,
    parameter int COLOR_W   = 8,
    parameter int BOX_SIZE  = 64,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] hPixel,
    input  logic [COORD_W-1:0] line,
    input  logic               video_active,
    input  logic               vSync,
    input  logic [2:0]         KEY,
    input  logic [9:0]         SW,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B
);

    localparam int CW    = COORD_W + 1;
    localparam int X_MAX = H_ACTIVE - BOX_SIZE;
    localparam int Y_MAX = V_ACTIVE - BOX_SIZE;
    localparam logic [CW-1:0] X_LIM = CW'(X_MAX);
    localparam logic [CW-1:0] Y_LIM = CW'(Y_MAX);
    localparam logic [CW-1:0] BOX_W = CW'(BOX_SIZE);

    logic [COORD_W-1:0]   x_q [NUM_BOXES];
    logic [COORD_W-1:0]   y_q [NUM_BOXES];
    logic [NUM_BOXES-1:0] dx_q;
    logic [NUM_BOXES-1:0] dy_q;
    logic [CW:0]          bx [NUM_BOXES];
    logic [CW:0]          by [NUM_BOXES];
    logic [NUM_BOXES-1:0] hit;
    logic [NUM_BOXES-1:0] hit_q;
    logic                 act_q;
    logic                 vs_d;
    logic                 strobe;
    logic [CW-1:0]        step;
    logic [2:0]           code_sel;
    logic                 unused_inputs;

    assign unused_inputs = ^{KEY[2], SW};

    // Reset positions are clamped so large NUM_BOXES never start outside the area.
    function automatic int rst_pos(input int idx, input int pitch, input int lim);
        return (idx * pitch > lim) ? lim : idx * pitch;
    endfunction

    // Returns {direction, position}; direction 1 = increasing coordinate.
    function automatic logic [CW:0] bounce(input logic [CW-1:0] pos, input logic fwd,
                                           input logic [CW-1:0] stp, input logic [CW-1:0] lim);
        logic [CW-1:0] p;
        logic          d;
        p = pos;
        d = fwd;
        if (fwd) begin
            if (pos + stp > lim) begin
                p = (lim >= stp) ? lim - stp : lim;
                d = 1'b0;
            end else begin
                p = pos + stp;
            end
        end else begin
            if (pos < stp) begin
                if (pos == '0)
                    p = '0;
                else
                    p = (stp - pos > lim) ? lim : stp - pos;
                d = 1'b1;
            end else begin
                p = pos - stp;
            end
        end
        return {d, p};
    endfunction

    assign strobe = vs_d & ~vSync;
    assign step   = KEY[1] ? CW'(1) : CW'(4);

    always_comb begin
        for (int i = 0; i < NUM_BOXES; i++) begin
            bx[i] = bounce(CW'(x_q[i]), dx_q[i], step, X_LIM);
            by[i] = bounce(CW'(y_q[i]), dy_q[i], step, Y_LIM);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_d <= 1'b1;
            dx_q <= '1;
            dy_q <= '1;
            for (int i = 0; i < NUM_BOXES; i++) begin
                x_q[i] <= COORD_W'(rst_pos(i, 128, X_MAX));
                y_q[i] <= COORD_W'(rst_pos(i, 96, Y_MAX));
            end
        end else begin
            vs_d <= vSync;
            if (strobe && KEY[0]) begin
                for (int i = 0; i < NUM_BOXES; i++) begin
                    x_q[i]  <= bx[i][COORD_W-1:0];
                    y_q[i]  <= by[i][COORD_W-1:0];
                    dx_q[i] <= bx[i][CW];
                    dy_q[i] <= by[i][CW];
                end
            end
        end
    end

    // Half-open hit window, compared one bit wider so x+BOX_SIZE cannot wrap.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            hit[i] = SW[i]
                   && (CW'(hPixel) >= CW'(x_q[i])) && (CW'(hPixel) < CW'(x_q[i]) + BOX_W)
                   && (CW'(line)   >= CW'(y_q[i])) && (CW'(line)   < CW'(y_q[i]) + BOX_W);
        end
    end

    always_comb begin
        code_sel = 3'd0;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (hit_q[i])
                code_sel = 3'((i % 7) + 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q <= '0;
            act_q <= 1'b0;
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else begin
            hit_q <= hit;
            act_q <= video_active;
            VGA_R <= (act_q && code_sel[0]) ? '1 : '0;
            VGA_G <= (act_q && code_sel[1]) ? '1 : '0;
            VGA_B <= (act_q && code_sel[2]) ? '1 : '0;
        end
    end

endmodule

// File: tb/tb_box_sprite_gen.sv
// Scoreboard bench for box_sprite_gen: directed pixels push expected colours,
// a negedge monitor pops and compares when the 2-clk latency expires.
module tb_box_sprite_gen;

    localparam logic [23:0] BLK = 24'h000000;
    localparam logic [23:0] RED = 24'hFF0000;
    localparam logic [23:0] GRN = 24'h00FF00;
    localparam logic [23:0] YEL = 24'hFFFF00;
    localparam logic [23:0] BLU = 24'h0000FF;

    typedef struct {
        string       nm;
        logic [23:0] exp;
        bit          big;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hPixel = '0;
    logic [10:0] line = '0;
    logic        video_active = 1'b0;
    logic        vSync = 1'b1;
    logic [2:0]  KEY = 3'b111;
    logic [9:0]  SW = 10'h00F;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic [7:0]  big_r, big_g, big_b;

    exp_t        sb_q[$];
    exp_t        e;
    logic [23:0] act;
    bit          issue = 1'b0;
    bit          p1 = 1'b0;
    bit          p2 = 1'b0;
    int          checks = 0;
    int          errors = 0;

    box_sprite_gen dut (
        .clk(clk), .reset(reset), .hPixel(hPixel), .line(line),
        .video_active(video_active), .vSync(vSync), .KEY(KEY), .SW(SW),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    box_sprite_gen #(.BOX_SIZE(200)) dut_big (
        .clk(clk), .reset(reset), .hPixel(hPixel), .line(line),
        .video_active(video_active), .vSync(vSync), .KEY(KEY), .SW(SW),
        .VGA_R(big_r), .VGA_G(big_g), .VGA_B(big_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1 <= issue;
        p2 <= p1;
    end

    always @(negedge clk) begin
        if (p2) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL underflow: output presented with no expected entry");
            end else begin
                e   = sb_q.pop_front();
                act = e.big ? {big_r, big_g, big_b} : {VGA_R, VGA_G, VGA_B};
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
                end
            end
        end
    end

    task automatic pix(input int px, input int py, input bit a, input logic [23:0] exp,
                       input string nm, input bit big = 1'b0);
        hPixel       = 11'(px);
        line         = 11'(py);
        video_active = a;
        issue        = 1'b1;
        sb_q.push_back('{nm, exp, big});
        @(negedge clk);
        issue = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vSync = 1'b0;
            @(negedge clk);
            vSync = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        drain();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset positions, palette, enables
        pix(10, 10, 1, RED, "box0_red");
        pix(130, 100, 1, GRN, "box1_green");
        pix(260, 200, 1, YEL, "box2_yellow");
        pix(400, 300, 1, BLU, "box3_blue");
        pix(150, 100, 1, GRN, "small_150_100");
        pix(150, 100, 1, RED, "big_priority", 1'b1);
        pix(210, 100, 1, GRN, "big_box1_only", 1'b1);
        drain();
        SW = 10'h00D;
        pix(130, 100, 1, BLK, "box1_disabled");
        drain();
        SW = 10'h00F;

        // single steps, normal and fast
        frames(1);
        pix(0, 0, 1, BLK, "step1_origin");
        pix(1, 1, 1, RED, "step1_corner");
        pix(64, 64, 1, RED, "step1_far");
        drain();
        KEY = 3'b101;
        frames(1);
        KEY = 3'b111;
        pix(4, 4, 1, BLK, "fast_before");
        pix(5, 5, 1, RED, "fast_corner");
        pix(68, 68, 1, RED, "fast_far");
        pix(69, 69, 1, BLK, "fast_past");

        // long run with bounces on both axes
        do_reset();
        SW = 10'h001;
        frames(416);
        pix(416, 416, 1, RED, "f416_corner");
        pix(415, 416, 1, BLK, "f416_left");
        pix(416, 415, 1, BLK, "f416_above");
        drain();
        frames(1);
        pix(417, 415, 1, RED, "ybounce_corner");
        pix(417, 414, 1, BLK, "ybounce_above");
        pix(417, 478, 1, RED, "ybounce_bottom");
        pix(417, 479, 1, BLK, "ybounce_below");
        drain();
        frames(159);
        pix(576, 256, 1, RED, "f576_corner");
        pix(575, 256, 1, BLK, "f576_left");
        pix(639, 319, 1, RED, "f576_far");
        drain();
        frames(1);
        pix(574, 255, 1, BLK, "xbounce_left");
        pix(575, 255, 1, RED, "xbounce_corner");
        pix(638, 318, 1, RED, "xbounce_far");
        drain();
        KEY = 3'b110;
        frames(10);
        KEY = 3'b111;
        pix(575, 255, 1, RED, "pause_corner");
        pix(574, 255, 1, BLK, "pause_left");
        pix(575, 254, 1, BLK, "pause_above");

        // blanking and asynchronous reset
        pix(600, 300, 0, BLK, "inactive_in_box");
        pix(600, 300, 1, RED, "active_in_box");
        drain();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({VGA_R, VGA_G, VGA_B, big_r, big_g, big_b} !== 48'h0) begin
            errors++;
            $display("FAIL async_reset: got %h %h expected 0",
                     {VGA_R, VGA_G, VGA_B}, {big_r, big_g, big_b});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pix(0, 0, 1, RED, "post_reset_origin");
        pix(63, 63, 1, RED, "post_reset_far");
        pix(64, 64, 1, BLK, "post_reset_past");
        drain();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d entries pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
